vga_plot_sink: RTL and testbench
================================

# vga_plot_sink

- Receiving end of the pixel-plot interface driven by the fractal renderer.
- Accepts single-cycle plot strobes (x, y, colour) with no backpressure and buffers them in a small FIFO.
- Converts coordinates to linear framebuffer addresses and writes them into the 320x240, 3-bit framebuffer through a write port shared with scan-out.
- Also performs full-screen clears and reports when a finished frame has been fully written.

## Interface
Parameters:
- FIFO_DEPTH, 8, plot buffer entries; power of two, at least 2
- CLEAR_COLOUR, 3'b000, colour written by a clear sweep

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- plot_x  in  9  pixel column
- plot_y  in  8  pixel row
- plot_colour  in  3  pixel colour
- plot  in  1  one-cycle plot strobe; x/y/colour valid in the same cycle
- src_done  in  1  level; the source has finished the frame
- clear  in  1  one-cycle request to fill the framebuffer with CLEAR_COLOUR
- fb_busy  in  1  scan-out owns the next memory slot; no pop this cycle
- fb_wr_en  out  1  registered write strobe; memory accepts every pulse
- fb_addr  out  17  registered linear address
- fb_data  out  3  registered write colour
- clearing  out  1  a clear sweep is in progress
- flushed  out  1  src_done is high, the FIFO is empty and no write is pending
- overflow  out  1  sticky; a plot was dropped because the FIFO was full
- oob  out  1  sticky; an out-of-range plot was discarded (only with the macro)

## Operation
- Reset values:
  - fb_wr_en, fb_addr, fb_data, clearing, overflow, oob, flushed: all 0.
  - FIFO empty, state S_RUN, clear counter 0.
- Push:
  - A plot strobe is pushed at the edge where it is sampled.
  - If the FIFO is full and no pop occurs in the same cycle, the plot is dropped and overflow is set.
  - When full, a push and a pop in the same cycle are both performed.
- Address arithmetic: fb_addr = (y<<8) + (y<<6) + x, computed in 17 bits with no multiplier.
- State S_RUN:
  - Each cycle with FIFO not empty and fb_busy=0: pop the head, then on the next cycle fb_wr_en=1 with the head's address and colour.
  - Otherwise fb_wr_en=0.
- Transition S_RUN -> S_CLEAR:
  - Triggered by a clear pulse.
  - clearing goes to 1 the next cycle, overflow and oob are cleared, and the counter is set to 0.
- State S_CLEAR:
  - Each cycle with fb_busy=0: write addr=counter, data=CLEAR_COLOUR, then increment the counter.
  - After writing address 76799, return to S_RUN and drop clearing on the same edge.
  - Plots arriving during the clear are still pushed; the FIFO is not drained until S_RUN.
  - A clear pulse received while in S_CLEAR is ignored.
- Reset mid-sweep aborts the clear: counter 0, clearing 0, FIFO contents discarded.
- flushed is registered and combines src_done, FIFO empty and no fb_wr_en in the current cycle. It deasserts the cycle after any push.

## Timing
- Plot sampled at edge E0; earliest fb_wr_en is the cycle after E1, a latency of 2 cycles with an empty FIFO and fb_busy=0.
- Sustained rate is 1 write per cycle while fb_busy=0; the FIFO absorbs fb_busy bursts of up to FIFO_DEPTH-1 cycles at full plot rate.
- fb_busy held high stalls pops indefinitely. Addresses and colours are written in strict plot order.
- A full clear takes 76800 cycles plus the number of cycles fb_busy is high.

## Configuration
- Macro: PLOT_BOUNDS_CHECK_EN.
- Defined:
  - Plots with x>=320 or y>=240 are discarded at push, never occupy the FIFO, and set oob.
- Undefined:
  - No range check; the address is computed as-is, truncated to 17 bits.
  - oob is tied to 0.

## Structure
- Shared package vga_fb_pkg holds:
  - Constants: FB_W=320, FB_H=240, FB_DEPTH=76800, FB_ADDR_W=17, COLOUR_W=3.
  - Typedef plot_t: struct of x[8:0], y[7:0], colour[2:0].
- Sub-module plot_fifo: synchronous FIFO of plot_t with push, pop, full and empty.
  - The address computation and state machine stay in vga_plot_sink.

## Test plan
- Single plot (x=5, y=2, colour=3'b101), fb_busy=0 -> exactly one fb_wr_en, two cycles later, with addr=645 and data=5.
- 20 back-to-back plots with fb_busy high for 4 cycles mid-stream -> all 20 written in order, overflow=0.
- FIFO_DEPTH=8, fb_busy held high, 9 plots -> 8 written after fb_busy drops, the 9th missing, overflow=1 until the next clear.
- Clear pulse with fb_busy=0 -> clearing high for 76800 cycles, addresses 0..76799 written with data 0, overflow cleared.
  - Plots injected mid-clear are written immediately after the sweep completes.
- With PLOT_BOUNDS_CHECK_EN, plot at (320,0) then (319,239) -> first discarded with oob=1, second written with addr=76799.
- Reset asserted mid-clear and mid-drain -> next cycle all outputs 0, state S_RUN; with src_done=1, flushed goes to 1 one cycle later.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared framebuffer constants, plot record and address helper.
package vga_fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_DEPTH  = 76800;
    localparam int FB_ADDR_W = 17;
    localparam int COLOUR_W  = 3;

    typedef struct packed {
        logic [8:0]          x;
        logic [7:0]          y;
        logic [COLOUR_W-1:0] colour;
    } plot_t;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_CLEAR = 1'b1
    } sink_state_e;

    // y*320 + x as two shifts and two adds; the result wraps at 17 bits.
    function automatic logic [FB_ADDR_W-1:0] fb_lin_addr(input logic [8:0] x,
                                                         input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yy;
        logic [FB_ADDR_W-1:0] xx;
        yy = {9'd0, y};
        xx = {8'd0, x};
        return (yy << 8) + (yy << 6) + xx;
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot records. Pointers carry one extra wrap bit so
// full and empty are distinguishable. The caller never pushes into a full
// FIFO unless it pops in the same cycle.
module plot_fifo
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  plot_t din,
    output plot_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    plot_t         mem_q [DEPTH];
    logic [AW:0]   wr_q, wr_d;
    logic [AW:0]   rd_q, rd_d;

    // Pointer advance on push/pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset discards all contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; entries need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/vga_plot_sink.sv
// Plot sink: buffers plot strobes, converts them to linear framebuffer
// addresses and writes them through the shared port; also sweeps the whole
// framebuffer on a clear request.
// Optional macro PLOT_BOUNDS_CHECK_EN discards off-screen plots and flags oob.
module vga_plot_sink
    import vga_fb_pkg::*;
#(
    parameter int                  FIFO_DEPTH   = 8,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8:0]           plot_x,
    input  logic [7:0]           plot_y,
    input  logic [COLOUR_W-1:0]  plot_colour,
    input  logic                 plot,
    input  logic                 src_done,
    input  logic                 clear,
    input  logic                 fb_busy,
    output logic                 fb_wr_en,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [COLOUR_W-1:0]  fb_data,
    output logic                 clearing,
    output logic                 flushed,
    output logic                 overflow,
    output logic                 oob
);

    sink_state_e          state_q, state_d;
    logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [COLOUR_W-1:0]  data_q, data_d;
    logic                 ovf_q, ovf_d;
    logic                 flushed_q, flushed_d;

    plot_t in_plot, head;
    logic  fifo_full, fifo_empty;
    logic  in_range, push, pop, drop_full, clear_start;

    assign in_plot = '{x: plot_x, y: plot_y, colour: plot_colour};

`ifdef PLOT_BOUNDS_CHECK_EN
    assign in_range = (plot_x < 9'(FB_W)) && (plot_y < 8'(FB_H));
`else
    assign in_range = 1'b1;
`endif

    // A clear request wins over a pop in the same cycle; the head stays
    // queued and is written after the sweep.
    assign clear_start = (state_q == S_RUN) && clear;
    assign pop         = (state_q == S_RUN) && !clear && !fifo_empty && !fb_busy;
    assign push        = plot && in_range && (!fifo_full || pop);
    assign drop_full   = plot && in_range && fifo_full && !pop;

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_plot),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state, write port and sticky flags.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        ovf_d     = ovf_q | drop_full;
        flushed_d = src_done && fifo_empty && !wr_en_q && !push;
        case (state_q)
            S_RUN: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (pop) begin
                    wr_en_d = 1'b1;
                    addr_d  = fb_lin_addr(head.x, head.y);
                    data_d  = head.colour;
                end
            end
            S_CLEAR: begin
                if (!fb_busy) begin
                    wr_en_d = 1'b1;
                    addr_d  = cnt_q;
                    data_d  = CLEAR_COLOUR;
                    if (cnt_q == FB_ADDR_W'(FB_DEPTH - 1)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            flushed_q <= flushed_d;
        end
    end

`ifdef PLOT_BOUNDS_CHECK_EN
    logic oob_q, oob_d;

    // Sticky off-screen flag, cleared when a sweep starts.
    always_comb begin
        oob_d = oob_q;
        if (clear_start)             oob_d = 1'b0;
        else if (plot && !in_range)  oob_d = 1'b1;
    end

    // Off-screen flag register.
    always_ff @(posedge clk) begin
        if (rst) oob_q <= 1'b0;
        else     oob_q <= oob_d;
    end

    assign oob = oob_q;
`else
    assign oob = 1'b0;
`endif

    assign fb_wr_en = wr_en_q;
    assign fb_addr  = addr_q;
    assign fb_data  = data_q;
    assign clearing = (state_q == S_CLEAR);
    assign flushed  = flushed_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: table of plot vectors plus hand-written
// sequences for stalls, overflow, clear sweep and reset. Expected writes go
// into a queue at drive time and are popped when fb_wr_en is seen.
module tb_vga_plot_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  plot_x;
    logic [7:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        plot, src_done, clear, fb_busy;
    logic        fb_wr_en;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        clearing, flushed, overflow, oob;

    vga_plot_sink dut (
        .clk(clk), .rst(rst), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot(plot), .src_done(src_done),
        .clear(clear), .fb_busy(fb_busy), .fb_wr_en(fb_wr_en),
        .fb_addr(fb_addr), .fb_data(fb_data), .clearing(clearing),
        .flushed(flushed), .overflow(overflow), .oob(oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] addr;
        logic [2:0]  data;
    } exp_t;

    typedef struct {
        logic [8:0]  x;
        logic [7:0]  y;
        logic [2:0]  c;
        logic [16:0] addr;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   clr_mode = 1'b0;
    int   clr_seen = 0;
    int   clr_err  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Write monitor: clear sweep writes are tracked by a running address,
    // everything else must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && fb_wr_en === 1'b1) begin
            if (clr_mode && clr_seen < 76800) begin
                if (fb_addr !== clr_seen[16:0] || fb_data !== 3'd0) clr_err++;
                clr_seen++;
            end else if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                         fb_addr, fb_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(fb_addr), 32'(e.addr));
                chk("wr_data", 32'(fb_data), 32'(e.data));
            end
        end
    end

    // Present one plot for one cycle; returns at the negedge after it was sampled.
    task automatic drive(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c,
                         input bit expect_wr, input logic [16:0] addr);
        exp_t e;
        plot_x = x; plot_y = y; plot_colour = c; plot = 1'b1;
        if (expect_wr) begin
            e.addr = addr;
            e.data = c;
            sb.push_back(e);
        end
        @(negedge clk);
        plot = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending writes expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        int cyc, ccount;
        logic [8:0] rx;
        logic [7:0] ry;

        tbl[0] = '{x: 9'd0,   y: 8'd0,   c: 3'd1, addr: 17'd0};
        tbl[1] = '{x: 9'd1,   y: 8'd1,   c: 3'd2, addr: 17'd321};
        tbl[2] = '{x: 9'd319, y: 8'd0,   c: 3'd3, addr: 17'd319};
        tbl[3] = '{x: 9'd0,   y: 8'd239, c: 3'd4, addr: 17'd76480};
        tbl[4] = '{x: 9'd319, y: 8'd239, c: 3'd7, addr: 17'd76799};
        tbl[5] = '{x: 9'd100, y: 8'd100, c: 3'd6, addr: 17'd32100};
        tbl[6] = '{x: 9'd160, y: 8'd120, c: 3'd5, addr: 17'd38560};
        tbl[7] = '{x: 9'd5,   y: 8'd2,   c: 3'd5, addr: 17'd645};

        rst = 1'b1; plot = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0;
        src_done = 1'b0; clear = 1'b0; fb_busy = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_wr_en",    32'(fb_wr_en), 0);
        chk("rst_addr",     32'(fb_addr),  0);
        chk("rst_data",     32'(fb_data),  0);
        chk("rst_clearing", 32'(clearing), 0);
        chk("rst_flushed",  32'(flushed),  0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_oob",      32'(oob),      0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single plot latency: write appears in the second cycle after sampling.
        drive(9'd5, 8'd2, 3'b101, 1'b1, 17'd645);
        chk("single_lat1", 32'(fb_wr_en), 0);
        @(negedge clk);
        chk("single_lat2", 32'(fb_wr_en), 1);
        @(negedge clk);
        chk("single_once", 32'(fb_wr_en), 0);
        wait_drain(20);

        // Table vectors back to back.
        for (int i = 0; i < 8; i++)
            drive(tbl[i].x, tbl[i].y, tbl[i].c, 1'b1, tbl[i].addr);
        wait_drain(50);

        // flushed follows src_done once idle, then drops after a push.
        src_done = 1'b1;
        repeat (2) @(negedge clk);
        chk("flushed_idle", 32'(flushed), 1);
        drive(9'd7, 8'd3, 3'd2, 1'b1, 17'd967);
        chk("flushed_after_push", 32'(flushed), 0);
        wait_drain(20);
        chk("flushed_redone", 32'(flushed), 1);
        src_done = 1'b0;

        // 20 plots with a 4-cycle stall mid-stream.
        for (int i = 0; i < 20; i++) begin
            if (i == 8)  fb_busy = 1'b1;
            if (i == 12) fb_busy = 1'b0;
            rx = 9'($urandom_range(319, 0));
            ry = 8'($urandom_range(239, 0));
            drive(rx, ry, 3'(i), 1'b1, 17'(int'(ry) * 320 + int'(rx)));
        end
        fb_busy = 1'b0;
        wait_drain(60);
        chk("stall_overflow", 32'(overflow), 0);

        // Overflow: stalled port, nine plots into an 8-deep FIFO.
        fb_busy = 1'b1;
        for (int i = 0; i < 9; i++)
            drive(9'(10 + i), 8'd1, 3'(i), (i < 8), 17'(330 + i));
        repeat (3) @(negedge clk);
        chk("ovf_stalled_no_wr", 32'(fb_wr_en), 0);
        chk("ovf_set", 32'(overflow), 1);
        fb_busy = 1'b0;
        wait_drain(40);
        chk("ovf_sticky", 32'(overflow), 1);

        // Clear sweep with three plots injected mid-sweep.
        clr_mode = 1'b1; clr_seen = 0; clr_err = 0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_overflow_cleared", 32'(overflow), 0);
        ccount = 0;
        cyc = 0;
        while (cyc < 80000 && !(ccount > 0 && clearing == 1'b0)) begin
            if (clearing) ccount++;
            if (ccount >= 100 && ccount < 103) begin
                exp_t e;
                plot_x = 9'(200 + ccount); plot_y = 8'd50; plot_colour = 3'd6; plot = 1'b1;
                e.addr = 17'(50 * 320 + 200 + ccount);
                e.data = 3'd6;
                sb.push_back(e);
            end else begin
                plot = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        plot = 1'b0;
        chk("clr_cycles", 32'(ccount), 76800);
        wait_drain(40);
        chk("clr_writes", 32'(clr_seen), 76800);
        chk("clr_bad_writes", 32'(clr_err), 0);
        chk("clr_overflow_after", 32'(overflow), 0);
        clr_mode = 1'b0;

        // Bounds handling.
`ifdef PLOT_BOUNDS_CHECK_EN
        drive(9'd320, 8'd0, 3'd1, 1'b0, 17'd0);
        drive(9'd319, 8'd239, 3'd2, 1'b1, 17'd76799);
        wait_drain(20);
        chk("oob_set", 32'(oob), 1);
`else
        drive(9'd320, 8'd0, 3'd1, 1'b1, 17'd320);
        wait_drain(20);
        chk("oob_tied", 32'(oob), 0);
`endif

        // Reset while a clear is stalled and the FIFO holds plots.
        fb_busy = 1'b1;
        for (int i = 0; i < 3; i++) drive(9'(i), 8'd9, 3'd3, 1'b0, 17'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_clear_clearing", 32'(clearing), 1);
        src_done = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fb_busy = 1'b0;
        chk("rst2_wr_en",    32'(fb_wr_en), 0);
        chk("rst2_addr",     32'(fb_addr),  0);
        chk("rst2_data",     32'(fb_data),  0);
        chk("rst2_clearing", 32'(clearing), 0);
        chk("rst2_overflow", 32'(overflow), 0);
        chk("rst2_flushed",  32'(flushed),  0);
        @(negedge clk);
        chk("rst2_flushed_next", 32'(flushed), 1);
        repeat (5) @(negedge clk);
        chk("rst2_still_idle", 32'(clearing), 0);
        chk("rst2_queue_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
